// File: rtl/branch_predictor_pkg.sv
// Shared types for the fetch-side branch predictor: 2-bit counter encodings,
// controller state codes and a sequential-PC helper.
package branch_predictor_pkg;

    typedef enum logic [1:0] {
        BP_SNT = 2'b00,
        BP_WNT = 2'b01,
        BP_WT  = 2'b10,
        BP_ST  = 2'b11
    } ctr_t;

    typedef enum logic {
        BP_INIT = 1'b0,
        BP_RUN  = 1'b1
    } bp_state_t;

    function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch lookup, execute update, redirect and statistics signals of the predictor.
// The slave modport is the predictor side; master is the pipeline side.
interface branch_predictor_if;

    logic [31:0] if_pc;
    logic        if_hit;
    logic        if_pred_taken;
    logic [31:0] if_pred_target;
    logic        bp_ready;

    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;

    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;

    modport slave (
        input  if_pc, upd_valid, upd_pc, upd_taken, upd_target,
               upd_pred_taken, upd_pred_target,
        output if_hit, if_pred_taken, if_pred_target, bp_ready,
               redirect_valid, redirect_pc, stat_branches, stat_mispredicts
    );

    modport master (
        output if_pc, upd_valid, upd_pc, upd_taken, upd_target,
               upd_pred_taken, upd_pred_target,
        input  if_hit, if_pred_taken, if_pred_target, bp_ready,
               redirect_valid, redirect_pc, stat_branches, stat_mispredicts
    );

endinterface

// File: rtl/branch_predictor_sat_counter2.sv
// 2-bit saturating up/down counter, combinational next value.
module sat_counter2
    import branch_predictor_pkg::*;
(
    input  ctr_t ctr,
    input  logic inc,
    output ctr_t ctr_next
);

    always_comb begin
        ctr_next = ctr;
        if (inc) begin
            if (ctr != BP_ST) ctr_next = ctr_t'(ctr + 2'd1);
        end else begin
            if (ctr != BP_SNT) ctr_next = ctr_t'(ctr - 2'd1);
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped 2-bit counter predictor with BTB: combinational fetch lookup,
// execute-time training, registered mispredict redirect and event counters.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int unsigned ENTRIES = 64
) (
    input  logic              clk,
    input  logic              rst,
    branch_predictor_if.slave bp
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = 32 - IDX_W - 2;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);
    localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];
    ctr_t             ctr_q    [ENTRIES];

    bp_state_t        state_q, state_d;
    logic [IDX_W-1:0] sweep_q, sweep_d;
    logic             run;

    logic [IDX_W-1:0] f_idx, u_idx;
    logic [TAG_W-1:0] f_tag, u_tag;
    logic             f_hit, u_hit, upd_fire, mispredict;
    ctr_t             u_ctr_next;

    logic             we, w_valid;
    logic [IDX_W-1:0] w_idx;
    logic [TAG_W-1:0] w_tag;
    logic [31:0]      w_target;
    ctr_t             w_ctr;

    logic             redirect_valid_q;
    logic [31:0]      redirect_pc_q, stat_branches_q, stat_mispredicts_q;

    logic             unused_pc_bits;
    assign unused_pc_bits = ^{bp.if_pc[1:0], bp.upd_pc[1:0]};

    assign run = (state_q == BP_RUN);

    assign f_idx = bp.if_pc[IDX_W+1:2];
    assign f_tag = bp.if_pc[31:IDX_W+2];
    assign f_hit = run && valid_q[f_idx] && (tag_q[f_idx] == f_tag);

    assign bp.if_hit         = f_hit;
    assign bp.if_pred_taken  = f_hit && ctr_q[f_idx][1];
    assign bp.if_pred_target = bp.if_pred_taken ? target_q[f_idx] : next_seq_pc(bp.if_pc);
    assign bp.bp_ready       = run;

    assign u_idx    = bp.upd_pc[IDX_W+1:2];
    assign u_tag    = bp.upd_pc[31:IDX_W+2];
    assign u_hit    = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    assign upd_fire = run && bp.upd_valid;

    assign mispredict = (bp.upd_pred_taken != bp.upd_taken) ||
                        (bp.upd_taken && (bp.upd_pred_target != bp.upd_target));

    sat_counter2 u_sat_counter2 (
        .ctr      (ctr_q[u_idx]),
        .inc      (bp.upd_taken),
        .ctr_next (u_ctr_next)
    );

    // Sweep and training share one write port; the sweep owns it during INIT.
    always_comb begin
        state_d  = state_q;
        sweep_d  = sweep_q;
        we       = 1'b0;
        w_idx    = sweep_q;
        w_valid  = 1'b0;
        w_tag    = '0;
        w_target = '0;
        w_ctr    = BP_WNT;
        case (state_q)
            BP_INIT: begin
                we      = 1'b1;
                sweep_d = sweep_q + ONE_IDX;
                if (sweep_q == LAST_IDX) state_d = BP_RUN;
            end
            BP_RUN: begin
                if (bp.upd_valid) begin
                    if (u_hit) begin
                        we       = 1'b1;
                        w_idx    = u_idx;
                        w_valid  = 1'b1;
                        w_tag    = u_tag;
                        w_target = bp.upd_taken ? bp.upd_target : target_q[u_idx];
                        w_ctr    = u_ctr_next;
                    end else if (bp.upd_taken) begin
                        we       = 1'b1;
                        w_idx    = u_idx;
                        w_valid  = 1'b1;
                        w_tag    = u_tag;
                        w_target = bp.upd_target;
                        w_ctr    = BP_WT;
                    end
                end
            end
            default: state_d = BP_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BP_INIT;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
        end
    end

    always_ff @(posedge clk) begin
        if (we && !rst) begin
            valid_q[w_idx]  <= w_valid;
            tag_q[w_idx]    <= w_tag;
            target_q[w_idx] <= w_target;
            ctr_q[w_idx]    <= w_ctr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            redirect_valid_q   <= 1'b0;
            redirect_pc_q      <= '0;
            stat_branches_q    <= '0;
            stat_mispredicts_q <= '0;
        end else begin
            redirect_valid_q <= upd_fire && mispredict;
            if (upd_fire && mispredict) begin
                redirect_pc_q      <= bp.upd_taken ? bp.upd_target : next_seq_pc(bp.upd_pc);
                stat_mispredicts_q <= stat_mispredicts_q + 32'd1;
            end
            if (upd_fire) stat_branches_q <= stat_branches_q + 32'd1;
        end
    end

    assign bp.redirect_valid   = redirect_valid_q;
    assign bp.redirect_pc      = redirect_pc_q;
    assign bp.stat_branches    = stat_branches_q;
    assign bp.stat_mispredicts = stat_mispredicts_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor (ENTRIES=64) with hand-computed expectations
// for sweep timing, lookup, training, aliasing, redirect and statistics.
module tb_branch_predictor;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total  = 0;
    int   passed = 0;
    int   failed = 0;

    branch_predictor_if bus ();

    branch_predictor #(.ENTRIES(64)) dut (
        .clk (clk),
        .rst (rst),
        .bp  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                       input logic ptaken, input logic [31:0] ptgt);
        bus.upd_valid       = 1'b1;
        bus.upd_pc          = pc;
        bus.upd_taken       = taken;
        bus.upd_target      = tgt;
        bus.upd_pred_taken  = ptaken;
        bus.upd_pred_target = ptgt;
    endtask

    task automatic lookup(input string tag, input logic [31:0] pc, input logic hit,
                          input logic taken, input logic [31:0] tgt);
        bus.if_pc = pc;
        #1;
        check({tag, "_hit"},    32'(bus.if_hit), 32'(hit));
        check({tag, "_taken"},  32'(bus.if_pred_taken), 32'(taken));
        check({tag, "_target"}, bus.if_pred_target, tgt);
    endtask

    task automatic stats(input string tag, input logic [31:0] br, input logic [31:0] mp);
        check({tag, "_branches"},    bus.stat_branches, br);
        check({tag, "_mispredicts"}, bus.stat_mispredicts, mp);
    endtask

    initial begin
        bus.if_pc = 32'h100;
        upd(32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        bus.upd_valid = 1'b0;

        tick(); tick();
        check("rst_ready", 32'(bus.bp_ready), 32'd0);
        check("rst_redirect_valid", 32'(bus.redirect_valid), 32'd0);
        check("rst_redirect_pc", bus.redirect_pc, 32'h0);
        stats("rst", 32'd0, 32'd0);
        lookup("rst_lookup", 32'h100, 1'b0, 1'b0, 32'h104);

        rst = 1'b0;
        repeat (63) tick();
        check("ready_low_after_63", 32'(bus.bp_ready), 32'd0);
        tick();
        check("ready_high_after_64", 32'(bus.bp_ready), 32'd1);
        lookup("cold_miss", 32'h100, 1'b0, 1'b0, 32'h104);
        lookup("wrap_pc", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0);

        // Allocate 0x100 -> 0x200 on a mispredicted taken branch
        upd(32'h100, 1'b1, 32'h200, 1'b0, 32'h104);
        lookup("same_cycle_old", 32'h100, 1'b0, 1'b0, 32'h104);
        tick();
        bus.upd_valid = 1'b0;
        check("alloc_redirect_valid", 32'(bus.redirect_valid), 32'd1);
        check("alloc_redirect_pc", bus.redirect_pc, 32'h200);
        stats("alloc", 32'd1, 32'd1);
        lookup("alloc_lookup", 32'h100, 1'b1, 1'b1, 32'h200);
        tick();
        check("redirect_one_cycle", 32'(bus.redirect_valid), 32'd0);

        // Not taken x3: 10 -> 01 -> 00 -> 00
        upd(32'h100, 1'b0, 32'h200, 1'b1, 32'h200);
        tick();
        check("nt1_redirect_valid", 32'(bus.redirect_valid), 32'd1);
        check("nt1_redirect_pc", bus.redirect_pc, 32'h104);
        upd(32'h100, 1'b0, 32'h200, 1'b0, 32'h104);
        tick();
        check("nt2_no_redirect", 32'(bus.redirect_valid), 32'd0);
        tick();
        bus.upd_valid = 1'b0;
        check("nt3_no_redirect", 32'(bus.redirect_valid), 32'd0);
        lookup("nt3_lookup", 32'h100, 1'b1, 1'b0, 32'h104);

        // Two taken updates back to back: floor held, so 00 -> 01 -> 10
        upd(32'h100, 1'b1, 32'h280, 1'b0, 32'h104);
        tick();
        check("bb1_redirect_valid", 32'(bus.redirect_valid), 32'd1);
        check("bb1_redirect_pc", bus.redirect_pc, 32'h280);
        lookup("floor_lookup", 32'h100, 1'b1, 1'b0, 32'h104);
        upd(32'h100, 1'b1, 32'h300, 1'b0, 32'h104);
        tick();
        bus.upd_valid = 1'b0;
        check("bb2_redirect_valid", 32'(bus.redirect_valid), 32'd1);
        check("bb2_redirect_pc", bus.redirect_pc, 32'h300);
        lookup("bb2_lookup", 32'h100, 1'b1, 1'b1, 32'h300);
        stats("bb2", 32'd6, 32'd4);

        // Direction right, target wrong
        upd(32'h100, 1'b1, 32'h300, 1'b1, 32'h280);
        tick();
        check("tgt_redirect_valid", 32'(bus.redirect_valid), 32'd1);
        check("tgt_redirect_pc", bus.redirect_pc, 32'h300);
        stats("tgt", 32'd7, 32'd5);

        // Correct prediction
        upd(32'h100, 1'b1, 32'h300, 1'b1, 32'h300);
        tick();
        bus.upd_valid = 1'b0;
        check("ok_no_redirect", 32'(bus.redirect_valid), 32'd0);
        stats("ok", 32'd8, 32'd5);

        // Alias: 0x200 shares index 0 with 0x100
        upd(32'h200, 1'b1, 32'h400, 1'b0, 32'h204);
        tick();
        bus.upd_valid = 1'b0;
        check("alias_redirect_pc", bus.redirect_pc, 32'h400);
        lookup("alias_old", 32'h100, 1'b0, 1'b0, 32'h104);
        lookup("alias_new", 32'h200, 1'b1, 1'b1, 32'h400);
        stats("alias", 32'd9, 32'd6);

        // Miss, not taken: no allocation
        upd(32'h300, 1'b0, 32'h0, 1'b0, 32'h304);
        tick();
        bus.upd_valid = 1'b0;
        check("ntmiss_no_redirect", 32'(bus.redirect_valid), 32'd0);
        lookup("ntmiss_keep", 32'h200, 1'b1, 1'b1, 32'h400);
        lookup("ntmiss_noalloc", 32'h300, 1'b0, 1'b0, 32'h304);
        stats("ntmiss", 32'd10, 32'd6);

        // Reset, then reset again mid-sweep; updates during INIT are ignored
        rst = 1'b1;
        tick();
        rst = 1'b0;
        stats("rst2", 32'd0, 32'd0);
        check("rst2_ready", 32'(bus.bp_ready), 32'd0);
        upd(32'h500, 1'b1, 32'h600, 1'b0, 32'h504);
        repeat (30) tick();
        check("init_ignore_redirect", 32'(bus.redirect_valid), 32'd0);
        stats("init_ignore", 32'd0, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (63) tick();
        check("restart_low_after_63", 32'(bus.bp_ready), 32'd0);
        tick();
        bus.upd_valid = 1'b0;
        check("restart_high_after_64", 32'(bus.bp_ready), 32'd1);
        stats("restart", 32'd0, 32'd0);
        lookup("restart_cleared", 32'h200, 1'b0, 1'b0, 32'h204);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Fetch-side companion to the execute-stage branch condition logic: predicts direction and target for the fetch PC from a direct-mapped table of 2-bit saturating counters plus target/tag storage (BTB). Execute reports each resolved branch back; the block trains its table and raises a one-cycle redirect when the earlier prediction was wrong. It also sweeps the table clear after reset and keeps prediction statistics.

## Interface
- `ENTRIES`, 64: table depth; power of two, ≥ 4. `IDX_W = log2(ENTRIES)`.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `if_pc`  in  32  fetch PC (word aligned).
- `if_hit`  out  1  valid entry with matching tag.
- `if_pred_taken`  out  1  predicted taken.
- `if_pred_target`  out  32  predicted next PC.
- `bp_ready`  out  1  table initialised; predictions meaningful.
- `upd_valid`  in  1  a conditional branch resolved this cycle.
- `upd_pc`  in  32  PC of that branch.
- `upd_taken`  in  1  resolved condition (execute branch condition output).
- `upd_target`  in  32  resolved taken target.
- `upd_pred_taken`, `upd_pred_target`  in  1, 32  prediction carried down the pipe with the branch.
- `redirect_valid`  out  1  mispredict; fetch must restart.
- `redirect_pc`  out  32  correct next PC.
- `stat_branches`, `stat_mispredicts`  out  32 each  event counters.

## Operation
- Index = `pc[IDX_W+1:2]`, tag = `pc[31:IDX_W+2]`. Entry = {valid, tag, target[31:0], ctr[1:0]}.
- FSM: INIT → RUN. INIT walks index 0..ENTRIES-1, one entry per cycle, writing valid=0, ctr=01 (weakly not-taken). After writing the last index, → RUN. `bp_ready` = (state == RUN).
- `rst` in any state: state ← INIT, sweep index ← 0, stats ← 0, `redirect_valid` ← 0. Reset mid-sweep restarts from 0.
- In INIT: `if_hit`=0, `if_pred_taken`=0, `if_pred_target`=`if_pc`+4; `upd_valid` ignored for training, redirect and stats.
- Predict (RUN, combinational): hit = valid & tag match; `if_pred_taken` = hit & ctr[1]; `if_pred_target` = `if_pred_taken` ? target : `if_pc`+4 (mod 2^32).
- Train (RUN, `upd_valid`), indexing by `upd_pc`:
  - hit: ctr saturating ±1 (00 floor, 11 ceiling); if `upd_taken`, target ← `upd_target`.
  - miss and `upd_taken`: allocate (overwrite) — valid=1, tag, target ← `upd_target`, ctr=10.
  - miss and not taken: no write.
- Mispredict = `upd_pred_taken` ≠ `upd_taken`, or (`upd_taken` & `upd_pred_target` ≠ `upd_target`).
- `redirect_pc` = `upd_taken` ? `upd_target` : `upd_pc`+4.
- `stat_branches` +1 per `upd_valid` in RUN; `stat_mispredicts` +1 per mispredict. Both wrap at 2^32.

## Timing
- Prediction: zero latency, combinational from `if_pc` and table state.
- Training write at the rising edge of the `upd_valid` cycle; same-cycle predict at the same index sees the old entry, the following cycle sees the new one.
- `redirect_valid`/`redirect_pc` registered: asserted exactly one cycle after the mispredicting `upd_valid`, for one cycle. Back-to-back mispredicts give back-to-back pulses, each with its own PC.
- Stats update at the same edge as training.
- `bp_ready` rises ENTRIES cycles after `rst` deasserts.
- Reset values: `bp_ready`=0, `redirect_valid`=0, `redirect_pc`=0, stats=0.

## Structure
- `defines.v` gains counter encodings `BP_SNT`=00, `BP_WNT`=01, `BP_WT`=10, `BP_ST`=11 and FSM state codes `BP_INIT`, `BP_RUN`.
- One sub-module: `sat_counter2` (2-bit saturating increment/decrement, combinational next-value).
- Table held in flop arrays; all writes, including the init sweep, through a single write port.

## Test plan
- Reset, ENTRIES=64: `bp_ready` low for 64 cycles, high on cycle 65; every lookup misses, `if_pred_target` = `if_pc`+4.
- Update pc=0x100, taken, target=0x200, pred not-taken: redirect next cycle with `redirect_pc`=0x200; lookup 0x100 then hits, predicts taken to 0x200, ctr=10.
- Same branch not taken ×3: ctr 10→01→00→00 (saturates); prediction not-taken, target 0x104.
- Alias 0x100 vs 0x200 (ENTRIES=64): taken update at 0x200 overwrites the entry; lookup 0x100 misses.
- Correct prediction (pred taken 0x200, actual taken 0x200): no redirect; `stat_branches`+1, `stat_mispredicts` unchanged.
- Assert `rst` mid-sweep (cycle 30): `bp_ready` stays low, sweep restarts, ready 64 cycles after release; stats 0.
